// File: rtl/cpu_pkg.sv
// ---------------------------------------------------------------------------
// cpu_pkg
// Shared core definitions used by the fetch front end:
//   XLEN / INSTR_W    - datapath and instruction widths
//   NOP_INSTR         - canonical RISC-V NOP (addi x0, x0, 0)
//   DEFAULT_RESET_PC  - default fetch PC after reset
//   fetch_entry_t     - one buffered instruction paired with its PC
//   fetch_state_t     - fetch FSM states
// ---------------------------------------------------------------------------
package cpu_pkg;

  localparam int XLEN    = 32;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [XLEN-1:0]    DEFAULT_RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] inst;
  } fetch_entry_t;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// ---------------------------------------------------------------------------
// fetch_fifo
// Generic synchronous FIFO with synchronous clear.
//   clk, rst_n  - clock, asynchronous active-low reset
//   push/wdata  - write request and data (dropped when full without a pop)
//   pop         - remove head (ignored when empty)
//   clear       - empty the FIFO; has priority over push and pop
//   rdata       - head entry (undefined content when empty)
//   count       - number of stored entries (0..DEPTH)
//   empty, full - occupancy flags
// DEPTH must be a power of two >= 2 so the pointers wrap naturally.
// ---------------------------------------------------------------------------
module fetch_fifo #(
  parameter int  DEPTH = 4,
  parameter int  WIDTH = 64,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_pop  = pop && !empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // NOTE: the storage array has no reset; an entry is only ever read after it
  // has been written, and leaving it unreset lets it map onto plain RAM/flops.
  always_ff @(posedge clk) begin
    if (do_push && !clear) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];

  // Upstream flow control must never push into a full FIFO without a pop.
  a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
    !(push && full && !pop && !clear));

endmodule

// File: rtl/if_fetch_queue.sv
// ---------------------------------------------------------------------------
// if_fetch_queue
// Instruction-fetch front end feeding the IF/ID register. Owns the fetch PC,
// issues in-order requests to a request/grant instruction memory with
// variable latency, buffers {pc, inst} pairs and hands them to IF/ID with a
// valid/ready handshake. Branch redirects flush the buffer and discard the
// responses that are still in flight for the old path.
//   clk_i, rst_i          - clock, asynchronous active-low reset
//   start_i               - fetch enable (level)
//   imem_req_o/addr_o     - memory request and word-aligned address
//   imem_gnt_i            - request accepted this cycle
//   imem_rvalid_i/rdata_i - in-order memory response
//   redirect_i/pc_i       - taken branch from ID and its target
//   inst_valid_o/inst_o/pc_o - head instruction presented to IF/ID
//   id_ready_i            - IF/ID write enable (pop)
// ---------------------------------------------------------------------------
module if_fetch_queue
  import cpu_pkg::*;
#(
  parameter int              DEPTH     = 4,
  parameter int              MAX_OUTST = 2,
  parameter logic [XLEN-1:0] RESET_PC  = DEFAULT_RESET_PC
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  output logic               imem_req_o,
  output logic [XLEN-1:0]    imem_addr_o,
  input  logic               imem_gnt_i,
  input  logic               imem_rvalid_i,
  input  logic [INSTR_W-1:0] imem_rdata_i,
  input  logic               redirect_i,
  input  logic [XLEN-1:0]    redirect_pc_i,
  output logic               inst_valid_o,
  output logic [INSTR_W-1:0] inst_o,
  output logic [XLEN-1:0]    pc_o,
  input  logic               id_ready_i
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUTST) + 1;

  fetch_state_t    state, state_next;
  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] resp_pc;
  logic [OW-1:0]   outstanding;
  logic [OW-1:0]   discard_cnt;

  logic [CW-1:0]   fifo_count;
  logic            fifo_empty;
  logic            unused_fifo_full;
  logic [$bits(fetch_entry_t)-1:0] fifo_rdata;
  fetch_entry_t    head;
  fetch_entry_t    push_entry;

  logic            issue;
  logic            push;
  logic            pop;
  logic [XLEN-1:0] target_pc;
  logic [31:0]     occupancy;
  logic            unused_redirect_bits;

  assign target_pc            = {redirect_pc_i[XLEN-1:2], 2'b00};
  assign unused_redirect_bits = ^redirect_pc_i[1:0];

  // Entries already buffered plus words still to come; issuing only while
  // this is below DEPTH means every response has a free slot waiting for it.
  assign occupancy = 32'(fifo_count) + 32'(outstanding);

  assign issue = imem_req_o && imem_gnt_i;
  // A response in a redirect cycle, or while old-path words are pending
  // discard, belongs to the abandoned path and is dropped.
  assign push  = imem_rvalid_i && !redirect_i && (discard_cnt == '0);
  assign pop   = !fifo_empty && id_ready_i && !redirect_i;

  assign push_entry = '{pc: resp_pc, inst: imem_rdata_i};
  assign head       = fifo_rdata;

  // ---- FSM: state register -------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= IDLE;
    else        state <= state_next;
  end

  // ---- FSM: next state -----------------------------------------------------
  // NOTE: every signal assigned in a combinational block gets a default first,
  // otherwise an unassigned path infers a latch.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: if (start_i)  state_next = RUN;
      RUN:  if (!start_i) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---- FSM: outputs --------------------------------------------------------
  always_comb begin
    imem_req_o   = (state == RUN) && !redirect_i &&
                   (occupancy < 32'(DEPTH)) &&
                   (32'(outstanding) < 32'(MAX_OUTST));
    imem_addr_o  = fetch_pc;
    inst_valid_o = !fifo_empty;
    // Zero the head fields when empty so stale storage never leaks out.
    inst_o       = fifo_empty ? '0 : head.inst;
    pc_o         = fifo_empty ? '0 : head.pc;
  end

  // ---- PCs, outstanding and discard counters -------------------------------
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      discard_cnt <= '0;
    end else begin
      // No request is issued in a redirect cycle, so issue is 0 there.
      outstanding <= outstanding + OW'(issue) - OW'(imem_rvalid_i);
      if (redirect_i) begin
        fetch_pc    <= target_pc;
        resp_pc     <= target_pc;
        // Everything still in flight after this cycle is old-path data.
        discard_cnt <= outstanding - OW'(imem_rvalid_i);
      end else begin
        if (issue) fetch_pc <= fetch_pc + 32'd4;
        if (push)  resp_pc  <= resp_pc + 32'd4;
        if (imem_rvalid_i && (discard_cnt != '0))
          discard_cnt <= discard_cnt - OW'(1);
      end
    end
  end

  fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(fetch_entry_t))
  ) u_fifo (
    .clk   (clk_i),
    .rst_n (rst_i),
    .push  (push),
    .pop   (pop),
    .clear (redirect_i),
    .wdata (push_entry),
    .rdata (fifo_rdata),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (unused_fifo_full)
  );

  a_rvalid_expected : assert property (@(posedge clk_i) disable iff (!rst_i)
    imem_rvalid_i |-> (outstanding != '0));

  a_counter_order : assert property (@(posedge clk_i) disable iff (!rst_i)
    (discard_cnt <= outstanding) && (32'(outstanding) <= 32'(MAX_OUTST)));

endmodule

// File: tb/tb_if_fetch_queue.sv
// ---------------------------------------------------------------------------
// tb_if_fetch_queue
// Directed bench for if_fetch_queue. A fixed-latency in-order memory model
// answers every grant with mem_word(addr); a negedge monitor logs granted
// addresses and instructions accepted by IF/ID. Each test task drives its
// scenario and compares the logs or live outputs against hand-derived values.
// ---------------------------------------------------------------------------
module tb_if_fetch_queue;
  import cpu_pkg::*;

  localparam int DEPTH     = 4;
  localparam int MAX_OUTST = 2;

  logic        clk = 1'b0;
  logic        rst_i = 1'b0;
  logic        start_i = 1'b0;
  logic        imem_req_o;
  logic [31:0] imem_addr_o;
  logic        imem_gnt_i = 1'b1;
  logic        imem_rvalid_i = 1'b0;
  logic [31:0] imem_rdata_i = '0;
  logic        redirect_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        inst_valid_o;
  logic [31:0] inst_o;
  logic [31:0] pc_o;
  logic        id_ready_i = 1'b0;

  if_fetch_queue #(
    .DEPTH     (DEPTH),
    .MAX_OUTST (MAX_OUTST),
    .RESET_PC  (32'h0000_0000)
  ) dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .imem_req_o    (imem_req_o),
    .imem_addr_o   (imem_addr_o),
    .imem_gnt_i    (imem_gnt_i),
    .imem_rvalid_i (imem_rvalid_i),
    .imem_rdata_i  (imem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .inst_valid_o  (inst_valid_o),
    .inst_o        (inst_o),
    .pc_o          (pc_o),
    .id_ready_i    (id_ready_i)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int mem_lat = 1;
  int tot_gnt = 0;
  int tot_rsp = 0;
  int first_gnt_cyc = -1;
  int first_valid_cyc = -1;

  logic [31:0] pend_addr[$];
  int          pend_due[$];
  logic [31:0] gnt_log[$];
  logic [31:0] obs_pc[$];
  logic [31:0] obs_inst[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[29:0], 2'b11} ^ 32'h5A00_0000;
  endfunction

  // Memory model: responses in grant order, mem_lat cycles after the grant.
  initial forever begin
    @(posedge clk);
    #1;
    cyc++;
    if (!rst_i) begin
      pend_addr.delete();
      pend_due.delete();
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = '0;
    end else if (pend_due.size() > 0 && pend_due[0] <= cyc) begin
      imem_rvalid_i = 1'b1;
      imem_rdata_i  = mem_word(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
      tot_rsp++;
    end else begin
      imem_rvalid_i = 1'b0;
      imem_rdata_i  = '0;
    end
  end

  // Monitor: handshakes are stable by the falling edge.
  always @(negedge clk) begin
    if (!rst_i) begin
      pend_addr.delete();
      pend_due.delete();
    end else begin
      if (imem_req_o && imem_gnt_i) begin
        gnt_log.push_back(imem_addr_o);
        pend_addr.push_back(imem_addr_o);
        pend_due.push_back(cyc + mem_lat);
        tot_gnt++;
        if (first_gnt_cyc < 0) first_gnt_cyc = cyc;
      end
      if (inst_valid_o && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (inst_valid_o && id_ready_i && !redirect_i) begin
        obs_pc.push_back(pc_o);
        obs_inst.push_back(inst_o);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic clear_logs();
    gnt_log.delete();
    obs_pc.delete();
    obs_inst.delete();
  endtask

  task automatic apply_reset();
    rst_i      = 1'b0;
    start_i    = 1'b0;
    redirect_i = 1'b0;
    id_ready_i = 1'b0;
    imem_gnt_i = 1'b1;
    tick(3);
    clear_logs();
    tot_gnt = 0;
    tot_rsp = 0;
    first_gnt_cyc   = -1;
    first_valid_cyc = -1;
    rst_i = 1'b1;
  endtask

  task automatic wait_obs(input int n, input string name);
    int budget = 60;
    while (obs_pc.size() < n && budget > 0) begin
      tick(1);
      budget--;
    end
    checks++;
    if (obs_pc.size() < n) begin
      errors++;
      $display("FAIL %s timeout: got %0d accepted instructions, need %0d", name, obs_pc.size(), n);
    end
  endtask

  task automatic wait_gnts(input int n, input string name);
    int budget = 60;
    while (tot_gnt < n && budget > 0) begin
      tick(1);
      budget--;
    end
    checks++;
    if (tot_gnt < n) begin
      errors++;
      $display("FAIL %s timeout: got %0d grants, need %0d", name, tot_gnt, n);
    end
  endtask

  task automatic test_reset();
    mem_lat = 1;
    apply_reset();
    tick(3);
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL rst_req got %b exp 0", imem_req_o); end
    checks++; if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL rst_addr got %h exp 00000000", imem_addr_o); end
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", inst_valid_o); end
    checks++; if (inst_o !== 32'h0) begin errors++; $display("FAIL rst_inst got %h exp 00000000", inst_o); end
    checks++; if (pc_o !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp 00000000", pc_o); end
    checks++; if (tot_gnt !== 0) begin errors++; $display("FAIL idle_no_issue got %0d grants exp 0", tot_gnt); end
  endtask

  task automatic test_stream();
    start_i    = 1'b1;
    id_ready_i = 1'b1;
    tick(20);
    checks++;
    if (gnt_log.size() < 8) begin
      errors++; $display("FAIL stream_gnt_count got %0d exp >= 8", gnt_log.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (gnt_log[i] !== 32'(4 * i)) begin
          errors++; $display("FAIL stream_addr[%0d] got %h exp %h", i, gnt_log[i], 32'(4 * i));
        end
      end
    end
    checks++;
    if (first_valid_cyc - first_gnt_cyc !== 2) begin
      errors++; $display("FAIL stream_latency got %0d exp 2", first_valid_cyc - first_gnt_cyc);
    end
    checks++;
    if (obs_pc.size() < 8) begin
      errors++; $display("FAIL stream_obs_count got %0d exp >= 8", obs_pc.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (obs_pc[i] !== 32'(4 * i) || obs_inst[i] !== mem_word(32'(4 * i))) begin
          errors++; $display("FAIL stream_out[%0d] got pc %h inst %h exp pc %h inst %h",
                             i, obs_pc[i], obs_inst[i], 32'(4 * i), mem_word(32'(4 * i)));
        end
      end
    end
  endtask

  task automatic test_stall();
    id_ready_i = 1'b0;
    tick(10);
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL stall_req got %b exp 0", imem_req_o); end
    checks++;
    if (tot_gnt - obs_pc.size() !== DEPTH) begin
      errors++; $display("FAIL stall_stored got %0d exp %0d", tot_gnt - obs_pc.size(), DEPTH);
    end
    checks++; if (inst_valid_o !== 1'b1) begin errors++; $display("FAIL stall_valid got %b exp 1", inst_valid_o); end
    id_ready_i = 1'b1;
    tick(12);
    for (int i = 0; i < obs_pc.size(); i++) begin
      checks++;
      if (obs_pc[i] !== 32'(4 * i) || obs_inst[i] !== mem_word(32'(4 * i))) begin
        errors++; $display("FAIL stall_seq[%0d] got pc %h inst %h exp pc %h", i, obs_pc[i], obs_inst[i], 32'(4 * i));
      end
    end
  endtask

  task automatic test_redirect();
    mem_lat = 3;
    apply_reset();
    start_i    = 1'b1;
    id_ready_i = 1'b1;
    wait_gnts(2, "redir_setup");
    // Two requests in flight, none answered yet.
    clear_logs();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0040;
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL redir_no_req got %b exp 0", imem_req_o); end
    tick(1);
    redirect_i = 1'b0;
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL redir_flush got %b exp 0", inst_valid_o); end
    wait_obs(2, "redir_target");
    checks++; if (gnt_log[0] !== 32'h40) begin errors++; $display("FAIL redir_addr got %h exp 00000040", gnt_log[0]); end
    checks++;
    if (obs_pc[0] !== 32'h40 || obs_inst[0] !== mem_word(32'h40)) begin
      errors++; $display("FAIL redir_first got pc %h inst %h exp pc 00000040 inst %h", obs_pc[0], obs_inst[0], mem_word(32'h40));
    end
    checks++; if (obs_pc[1] !== 32'h44) begin errors++; $display("FAIL redir_second got %h exp 00000044", obs_pc[1]); end
  endtask

  task automatic test_redirect_rvalid_pop();
    int budget = 40;
    int outst_now = 0;
    bit found = 0;
    mem_lat = 3;
    apply_reset();
    start_i    = 1'b1;
    id_ready_i = 1'b0;
    while (!found && budget > 0) begin
      tick(1);
      budget--;
      outst_now = tot_gnt - tot_rsp + (imem_rvalid_i ? 1 : 0);
      found = imem_rvalid_i && inst_valid_o && (outst_now == 2);
    end
    checks++;
    if (!found) begin
      errors++; $display("FAIL rvpop_setup timeout: no cycle with response, valid head and 2 outstanding");
    end
    clear_logs();
    id_ready_i    = 1'b1;
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0080;
    tick(1);
    redirect_i = 1'b0;
    checks++;
    if (32'(dut.discard_cnt) !== outst_now - 1) begin
      errors++; $display("FAIL rvpop_discard got %0d exp %0d", dut.discard_cnt, outst_now - 1);
    end
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL rvpop_flush got %b exp 0", inst_valid_o); end
    wait_obs(1, "rvpop_target");
    checks++;
    if (obs_pc[0] !== 32'h80 || obs_inst[0] !== mem_word(32'h80)) begin
      errors++; $display("FAIL rvpop_first got pc %h inst %h exp pc 00000080", obs_pc[0], obs_inst[0]);
    end
  endtask

  task automatic test_align_wrap();
    mem_lat = 1;
    apply_reset();
    start_i    = 1'b1;
    id_ready_i = 1'b1;
    tick(4);
    clear_logs();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0102;
    tick(1);
    redirect_i = 1'b0;
    wait_obs(1, "align_target");
    checks++; if (gnt_log[0] !== 32'h100) begin errors++; $display("FAIL align_addr got %h exp 00000100", gnt_log[0]); end
    checks++; if (obs_pc[0] !== 32'h100) begin errors++; $display("FAIL align_pc got %h exp 00000100", obs_pc[0]); end
    clear_logs();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'hFFFF_FFFC;
    tick(1);
    redirect_i = 1'b0;
    wait_obs(2, "wrap_target");
    checks++; if (gnt_log[0] !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_addr0 got %h exp fffffffc", gnt_log[0]); end
    checks++; if (gnt_log[1] !== 32'h0) begin errors++; $display("FAIL wrap_addr1 got %h exp 00000000", gnt_log[1]); end
    checks++; if (obs_pc[0] !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_pc0 got %h exp fffffffc", obs_pc[0]); end
    checks++;
    if (obs_pc[1] !== 32'h0 || obs_inst[1] !== mem_word(32'h0)) begin
      errors++; $display("FAIL wrap_pc1 got pc %h inst %h exp pc 00000000 inst %h", obs_pc[1], obs_inst[1], mem_word(32'h0));
    end
  endtask

  task automatic test_back_to_back();
    mem_lat = 3;
    apply_reset();
    start_i    = 1'b1;
    id_ready_i = 1'b1;
    tick(5);
    clear_logs();
    redirect_i    = 1'b1;
    redirect_pc_i = 32'h0000_0200;
    tick(1);
    redirect_pc_i = 32'h0000_0300;
    tick(1);
    redirect_i = 1'b0;
    wait_obs(2, "b2b_target");
    checks++; if (gnt_log[0] !== 32'h300) begin errors++; $display("FAIL b2b_addr got %h exp 00000300", gnt_log[0]); end
    checks++; if (obs_pc[0] !== 32'h300) begin errors++; $display("FAIL b2b_pc0 got %h exp 00000300", obs_pc[0]); end
    checks++; if (obs_pc[1] !== 32'h304) begin errors++; $display("FAIL b2b_pc1 got %h exp 00000304", obs_pc[1]); end
  endtask

  task automatic test_reset_inflight();
    mem_lat = 3;
    apply_reset();
    start_i    = 1'b1;
    id_ready_i = 1'b1;
    wait_gnts(2, "rstfl_setup");
    #1;
    rst_i = 1'b0;
    #1;
    checks++; if (imem_req_o !== 1'b0) begin errors++; $display("FAIL rstfl_req got %b exp 0", imem_req_o); end
    checks++; if (imem_addr_o !== 32'h0) begin errors++; $display("FAIL rstfl_addr got %h exp 00000000", imem_addr_o); end
    checks++; if (inst_valid_o !== 1'b0) begin errors++; $display("FAIL rstfl_valid got %b exp 0", inst_valid_o); end
    checks++; if (pc_o !== 32'h0 || inst_o !== 32'h0) begin errors++; $display("FAIL rstfl_data got pc %h inst %h exp 0", pc_o, inst_o); end
    apply_reset();
    tick(2);
    checks++; if (tot_gnt !== 0) begin errors++; $display("FAIL rstfl_idle got %0d grants exp 0", tot_gnt); end
    start_i    = 1'b1;
    id_ready_i = 1'b1;
    wait_obs(2, "rstfl_resume");
    checks++; if (gnt_log[0] !== 32'h0) begin errors++; $display("FAIL rstfl_addr0 got %h exp 00000000", gnt_log[0]); end
    checks++;
    if (obs_pc[0] !== 32'h0 || obs_inst[0] !== mem_word(32'h0)) begin
      errors++; $display("FAIL rstfl_pc0 got pc %h inst %h exp pc 00000000 inst %h", obs_pc[0], obs_inst[0], mem_word(32'h0));
    end
    checks++; if (obs_pc[1] !== 32'h4) begin errors++; $display("FAIL rstfl_pc1 got %h exp 00000004", obs_pc[1]); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_rvalid_pop();
    test_align_wrap();
    test_back_to_back();
    test_reset_inflight();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
